// File: rtl/keccak_arb_pkg.sv
// Shared types and constants for the keccak core arbiter.
// Optional build macro KECCAK_ARB_FIXED_PRIO_EN selects fixed-priority picking.
package keccak_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } arb_state_e;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b01;
    localparam logic [1:0] MODE_SHA3_256 = 2'b10;
    localparam logic [1:0] MODE_SHA3_512 = 2'b11;

    localparam int N_REQ_DEFAULT = 4;

endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational requester picker: one-hot grant plus index.
// Round-robin from ptr by default; KECCAK_ARB_FIXED_PRIO_EN makes lowest index win.
module keccak_rr_pick
    import keccak_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found;

    assign any = |req;

`ifdef KECCAK_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                gnt_oh[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end
`else
    // First pass covers bits at or above ptr, second pass handles the wrap.
    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                found     = 1'b1;
                gnt_oh[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                gnt_oh[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak sponge core between N_REQ hash clients, one job at a time.
// Build macro KECCAK_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module keccak_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEFAULT,
    parameter int BW_DATA  = 64,
    parameter int BW_IBLEN = 12,
    parameter int BW_OBLEN = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [2*N_REQ-1:0]        i_req_mode,
    input  logic [N_REQ*BW_IBLEN-1:0] i_req_ibytes_len,
    input  logic [N_REQ*BW_OBLEN-1:0] i_req_obytes_len,
    input  logic [N_REQ*BW_DATA-1:0]  i_req_ibytes,
    input  logic [N_REQ-1:0]          i_req_ibytes_valid,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_req_ibytes_ready,
    output logic [BW_DATA-1:0]        o_req_obytes,
    output logic [N_REQ-1:0]          o_req_obytes_valid,
    output logic [N_REQ-1:0]          o_req_obytes_done,
    output logic [1:0]                o_kc_mode,
    output logic [BW_IBLEN-1:0]       o_kc_ibytes_len,
    output logic [BW_OBLEN-1:0]       o_kc_obytes_len,
    output logic [BW_DATA-1:0]        o_kc_ibytes,
    output logic                      o_kc_ibytes_valid,
    input  logic                      i_kc_ibytes_ready,
    input  logic [BW_DATA-1:0]        i_kc_obytes,
    input  logic                      i_kc_obytes_valid,
    input  logic                      i_kc_obytes_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [BW_IBLEN-1:0] ilen_q, ilen_d;
    logic [BW_OBLEN-1:0] olen_q, olen_d;
    logic [IDX_W-1:0]    ptr_cur;

    logic [N_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

`ifdef KECCAK_ARB_FIXED_PRIO_EN
    assign ptr_cur = '0;
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign ptr_cur = ptr_q;

    // Pointer moves past the finishing winner as the FSM enters S_RELEASE.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_BUSY && i_kc_obytes_done) begin
            ptr_d = (gidx_q == IDX_W'(N_REQ-1)) ? '0 : gidx_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    keccak_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (i_req),
        .ptr    (ptr_cur),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        ilen_d  = ilen_q;
        olen_d  = olen_q;
        unique case (state_q)
            S_IDLE, S_RELEASE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
                if (pick_any) begin
                    state_d = S_GRANT;
                    gidx_d  = pick_idx;
                    gnt_d   = pick_oh;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (IDX_W'(i) == pick_idx) begin
                            mode_d = i_req_mode[2*i +: 2];
                            ilen_d = i_req_ibytes_len[BW_IBLEN*i +: BW_IBLEN];
                            olen_d = i_req_obytes_len[BW_OBLEN*i +: BW_OBLEN];
                        end
                    end
                end
            end
            S_GRANT: state_d = S_BUSY;
            S_BUSY: begin
                if (i_kc_obytes_done) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            gnt_q   <= '0;
            mode_q  <= '0;
            ilen_q  <= '0;
            olen_q  <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            ilen_q  <= ilen_d;
            olen_q  <= olen_d;
        end
    end

    assign o_gnt           = gnt_q;
    assign o_kc_mode       = mode_q;
    assign o_kc_ibytes_len = ilen_q;
    assign o_kc_obytes_len = olen_q;
    assign o_req_obytes    = i_kc_obytes;

    // Streams are only connected in S_BUSY, so S_GRANT gives the core a quiet config cycle.
    always_comb begin
        o_kc_ibytes        = '0;
        o_kc_ibytes_valid  = 1'b0;
        o_req_ibytes_ready = '0;
        o_req_obytes_valid = '0;
        o_req_obytes_done  = '0;
        if (state_q == S_BUSY) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (IDX_W'(i) == gidx_q) begin
                    o_kc_ibytes           = i_req_ibytes[BW_DATA*i +: BW_DATA];
                    o_kc_ibytes_valid     = i_req_ibytes_valid[i];
                    o_req_ibytes_ready[i] = i_kc_ibytes_ready;
                    o_req_obytes_valid[i] = i_kc_obytes_valid;
                    o_req_obytes_done[i]  = i_kc_obytes_done;
                end
            end
        end
    end

endmodule
